// File: rtl/ps2_host_tx_pkg.sv
// Shared types and constants for the PS/2 host transmitter (and the receiver side).
package ps2_host_tx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    REQ,
    SEND,
    ACK,
    WAIT_IDLE
  } state_t;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_TIMEOUT = 2'b01;
  localparam logic [1:0] ERR_NOACK   = 2'b10;

  // Bits clocked out after the start bit: 8 data, parity, stop.
  localparam int FRAME_TX_BITS = 10;

  localparam logic [7:0] CMD_SET_LEDS = 8'hED;
  localparam logic [7:0] CMD_RESET    = 8'hFF;

  // {stop, odd parity, data}; shifted out from bit 0 upwards.
  function automatic logic [FRAME_TX_BITS-1:0] build_frame(input logic [7:0] d);
    return {1'b1, ~^d, d};
  endfunction

endpackage

// File: rtl/ps2_host_tx_if.sv
// Command request / status bundle between a controller and the PS/2 transmitter.
interface ps2_host_tx_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       busy;
  logic       done;
  logic       error;
  logic [1:0] error_code;

  modport master (
    output tx_data, tx_valid,
    input  tx_ready, busy, done, error, error_code
  );

  modport slave (
    input  tx_data, tx_valid,
    output tx_ready, busy, done, error, error_code
  );
endinterface

// File: rtl/ps2_line_sync.sv
// Two-flop synchroniser plus falling-edge detect for one open-drain PS/2 line.
module ps2_line_sync (
  input  logic vga_clk,
  input  logic reset,
  input  logic i_pin,
  output logic o_sync,
  output logic o_fall
);
  logic r_meta, r_sync, r_prev;

  // Lines idle high, so reset to 1 to avoid a phantom fall after reset.
  always_ff @(posedge vga_clk) begin
    if (reset) begin
      r_meta <= 1'b1;
      r_sync <= 1'b1;
      r_prev <= 1'b1;
    end else begin
      r_meta <= i_pin;
      r_sync <= r_meta;
      r_prev <= r_sync;
    end
  end

  assign o_sync = r_sync;
  assign o_fall = r_prev & ~r_sync;
endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibit, request-to-send, clock out
// data/parity/stop on device clock falls, check the ack, wait for bus idle.
module ps2_host_tx
  import ps2_host_tx_pkg::*;
#(
  parameter int INHIBIT_CYCLES   = 3000,
  parameter int DATA_LEAD_CYCLES = 16,
  parameter int TIMEOUT_CYCLES   = 425000,
  parameter int CNT_W            = 19
) (
  input  logic         vga_clk,
  input  logic         reset,
  ps2_host_tx_if.slave bus,
  input  logic         ps2_clk_in,
  input  logic         ps2_data_in,
  output logic         ps2_clk_oe,
  output logic         ps2_data_oe
);
  localparam logic [CNT_W-1:0] INH_LAST  = CNT_W'(INHIBIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] LEAD_LAST = CNT_W'(DATA_LEAD_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_LIMIT  = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [3:0]       LAST_IDX  = 4'(FRAME_TX_BITS - 1);

  logic w_clk_sync, w_clk_fall, w_data_sync, w_data_fall_unused;

  ps2_line_sync u_clk_sync (
    .vga_clk (vga_clk),
    .reset   (reset),
    .i_pin   (ps2_clk_in),
    .o_sync  (w_clk_sync),
    .o_fall  (w_clk_fall)
  );

  ps2_line_sync u_data_sync (
    .vga_clk (vga_clk),
    .reset   (reset),
    .i_pin   (ps2_data_in),
    .o_sync  (w_data_sync),
    .o_fall  (w_data_fall_unused)
  );

  state_t                   r_state, w_state;
  logic [CNT_W-1:0]         r_cnt, w_cnt, w_cnt_inc;
  logic [3:0]               r_idx, w_idx;
  logic [FRAME_TX_BITS-1:0] r_shreg, w_shreg;
  logic                     r_clk_oe, w_clk_oe;
  logic                     r_data_oe, w_data_oe;
  logic                     r_done, w_done;
  logic                     r_error, w_error;
  logic [1:0]               r_err_code, w_err_code;
  logic                     w_watched;

  // Next-state and next-output decode; timeout overrides everything in the device-clocked states.
  always_comb begin
    w_state    = r_state;
    w_cnt      = r_cnt;
    w_idx      = r_idx;
    w_shreg    = r_shreg;
    w_clk_oe   = r_clk_oe;
    w_data_oe  = r_data_oe;
    w_err_code = r_err_code;
    w_done     = 1'b0;
    w_error    = 1'b0;
    w_cnt_inc  = (&r_cnt) ? r_cnt : r_cnt + 1'b1;
    w_watched  = (r_state == SEND) || (r_state == ACK) || (r_state == WAIT_IDLE);

    case (r_state)
      IDLE: begin
        if (bus.tx_valid) begin
          w_shreg    = build_frame(bus.tx_data);
          w_err_code = ERR_NONE;
          w_cnt      = '0;
          w_clk_oe   = 1'b1;
          w_data_oe  = 1'b0;
          w_state    = INHIBIT;
        end
      end
      INHIBIT: begin
        if (r_cnt == INH_LAST) begin
          w_cnt     = '0;
          w_data_oe = 1'b1;
          w_state   = REQ;
        end else begin
          w_cnt = w_cnt_inc;
        end
      end
      REQ: begin
        if (r_cnt == LEAD_LAST) begin
          w_cnt    = '0;
          w_idx    = '0;
          w_clk_oe = 1'b0;
          w_state  = SEND;
        end else begin
          w_cnt = w_cnt_inc;
        end
      end
      SEND: begin
        if (w_clk_fall) begin
          w_data_oe = ~r_shreg[r_idx];
          w_idx     = r_idx + 1'b1;
          w_cnt     = '0;
          if (r_idx == LAST_IDX) w_state = ACK;
        end else begin
          w_cnt = w_cnt_inc;
        end
      end
      ACK: begin
        if (w_clk_fall) begin
          if (w_data_sync) w_err_code = ERR_NOACK;
          w_cnt   = '0;
          w_state = WAIT_IDLE;
        end else begin
          w_cnt = w_cnt_inc;
        end
      end
      WAIT_IDLE: begin
        w_clk_oe  = 1'b0;
        w_data_oe = 1'b0;
        if (w_clk_sync && w_data_sync) begin
          w_done  = 1'b1;
          w_error = (r_err_code != ERR_NONE);
          w_state = IDLE;
        end else begin
          w_cnt = w_cnt_inc;
        end
      end
      default: w_state = IDLE;
    endcase

    if (w_watched && (r_cnt >= TO_LIMIT)) begin
      w_clk_oe   = 1'b0;
      w_data_oe  = 1'b0;
      w_err_code = ERR_TIMEOUT;
      w_done     = 1'b1;
      w_error    = 1'b1;
      w_state    = IDLE;
    end
  end

  // State and output registers; reset drops both lines on the next edge.
  always_ff @(posedge vga_clk) begin
    if (reset) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_idx      <= '0;
      r_shreg    <= '0;
      r_clk_oe   <= 1'b0;
      r_data_oe  <= 1'b0;
      r_done     <= 1'b0;
      r_error    <= 1'b0;
      r_err_code <= ERR_NONE;
    end else begin
      r_state    <= w_state;
      r_cnt      <= w_cnt;
      r_idx      <= w_idx;
      r_shreg    <= w_shreg;
      r_clk_oe   <= w_clk_oe;
      r_data_oe  <= w_data_oe;
      r_done     <= w_done;
      r_error    <= w_error;
      r_err_code <= w_err_code;
    end
  end

  assign bus.tx_ready   = (r_state == IDLE);
  assign bus.busy       = (r_state != IDLE);
  assign bus.done       = r_done;
  assign bus.error      = r_error;
  assign bus.error_code = r_err_code;
  assign ps2_clk_oe     = r_clk_oe;
  assign ps2_data_oe    = r_data_oe;
endmodule

// File: doc/ps2_host_tx.md
Name: ps2_host_tx

Overview:
PS/2 host-to-device transmitter. It sends command bytes to the keyboard, for example 0xED (set LEDs) or 0xFF (reset), using the open-drain clock and data lines. It is the opposite direction to the existing PS/2 keyboard receiver and runs on the same 28.375 MHz vga_clk domain. While it is busy, the receiver must discard frames.

Parameters:
INHIBIT_CYCLES, 3000, cycles the host holds clock low before the request (about 106 µs).
DATA_LEAD_CYCLES, 16, cycles data is held low with clock still low, before clock is released.
TIMEOUT_CYCLES, 425000, maximum cycles between device clock falls, or waiting for bus idle (about 15 ms).
CNT_W, 19, width of the cycle counter.

Ports:
vga_clk  in  1  clock
reset  in  1  synchronous, active-high reset
tx_data  in  8  command byte
tx_valid  in  1  request to send; accepted when tx_valid && tx_ready
tx_ready  out  1  high only in IDLE
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse when a frame finishes (with or without error)
error  out  1  one-cycle pulse, coincident with done, on failure
error_code  out  2  00 none, 01 timeout, 10 no ack; held until the next accept
ps2_clk_in  in  1  raw PS/2 clock pin (asynchronous)
ps2_data_in  in  1  raw PS/2 data pin (asynchronous)
ps2_clk_oe  out  1  1 = drive clock low, 0 = release
ps2_data_oe  out  1  1 = drive data low, 0 = release

Behaviour:
- Clock/reset: reset reset, synchronous, active-high; clock vga_clk.
- Input conditioning: 2-FF synchroniser per pin, then a previous-value register. clk_fall = prev & ~sync. All protocol decisions use synced values only.
- Reset values: state IDLE, tx_ready 1, busy 0, done 0, error 0, error_code 00, both oe 0, counters 0.
- Reset mid-frame: the next edge releases both lines. No done/error pulse is produced.
- Accept: in IDLE with tx_valid=1, latch shreg = {1'b1 stop, ~^tx_data odd parity, tx_data}. Clear error_code, clear the cycle counter, go to INHIBIT. tx_valid outside IDLE is ignored and has no effect.
- INHIBIT: clk_oe=1, data_oe=0 for INHIBIT_CYCLES cycles, then go to REQ.
- REQ: clk_oe=1, data_oe=1 (start bit) for DATA_LEAD_CYCLES cycles, then go to SEND with clk_oe=0, bit index 0, counter 0.
- SEND: data_oe keeps its value until a clk_fall.
  - On each clk_fall: data_oe <= ~shreg[idx], idx++, counter cleared.
  - Edges 1–8 present data bits LSB first.
  - Edge 9 presents parity.
  - Edge 10 presents stop (data_oe=0, released). Then go to ACK.
- ACK: on the next clk_fall, sample data sync. 0 = acked; 1 = set error_code 10. Then go to WAIT_IDLE.
- WAIT_IDLE: both oe 0. When clk sync=1 and data sync=1: pulse done (and error if error_code≠00), then go to IDLE.
- Timeout: in SEND, ACK and WAIT_IDLE, the counter increments each cycle and clears on clk_fall. On reaching TIMEOUT_CYCLES:
  - release both lines;
  - error_code=01 (overrides 10);
  - pulse done and error;
  - go to IDLE.
- Counter saturates; it never wraps.
- Outputs: all registered. tx_ready and busy are decoded from the state register. done and error are single-cycle pulses.
- A clk_fall seen in INHIBIT or REQ is ignored. The host owns the clock line in those states.

Decomposition:
- ps2_pkg:
  - state enum {IDLE, INHIBIT, REQ, SEND, ACK, WAIT_IDLE};
  - ERR_NONE/ERR_TIMEOUT/ERR_NOACK constants;
  - FRAME_TX_BITS=10;
  - command constants CMD_SET_LEDS=8'hED, CMD_RESET=8'hFF.
- Sub-module ps2_line_sync: 2-FF synchroniser plus fall detect for one line. It is instantiated twice here, and the receiver is to reuse it.

Test Plan:
1. Send 0xED; device model clocks at 12.5 kHz (about 2270 cycles/period) and acks low.
   - Required: clk held low ≥3000 cycles.
   - Required: bits presented 1,0,1,1,0,1,1,1, then parity 1, then stop released.
   - Required: done pulse, error 0, error_code 00, tx_ready back to 1.
2. Send 0x01; device leaves data high on edge 11 → parity bit 0 presented; done+error pulse, error_code 10.
3. Send 0xFF; device never clocks.
   - Required: TIMEOUT_CYCLES after REQ ends, both oe go to 0.
   - Required: done+error pulse, error_code 01.
4. Hold tx_valid=1 with tx_data changing during a 0xF4 frame → exactly one frame; 0xF4 bits sent; no second accept until tx_ready returns.
5. Assert reset during data bit 4 → next cycle both oe 0, tx_ready 1, busy 0; no done pulse; a later 0xED send completes normally.
6. Two sends back-to-back (0xED then 0x02) → second accepted on the first cycle tx_ready=1 after done; the second frame's parity is 0.
